// File: rtl/axilite_mmap_pkg.sv
// Shared AXI-Lite response codes, FSM state encodings and default map
// placement for the sparse-map register slave.
package axilite_mmap_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0001_0000;
    localparam int          DEF_SLOT_LOG2 = 14;

    typedef enum logic [1:0] {
        W_ADDR,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic {
        R_ADDR,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axilite_mmap_regfile.sv
// Register bank with one byte-strobed write port and one combinational
// read port; a read and a write in the same cycle see the old contents.
module axilite_mmap_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          widx_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic [IDX_W-1:0]          ridx_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb_i[b]) regs_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/axilite_slave_mmap.sv
// AXI4-Lite slave: NUM_REGS registers, one per 2**SLOT_LOG2 slot above BASE_ADDR.
// Define AXIL_MMAP_ADDR_ERR_EN to answer out-of-window accesses with SLVERR.
module axilite_slave_mmap
    import axilite_mmap_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = DEF_BASE_ADDR,
    parameter int                    SLOT_LOG2  = DEF_SLOT_LOG2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int IDX_W = $clog2(NUM_REGS);

    wstate_e                 wstate_q, wstate_d;
    rstate_e                 rstate_q, rstate_d;
    logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, reg_rdata;
    logic                    reg_we, aw_ok, ar_ok;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID  & wready_q;
    assign b_hs  = S_AXI_BREADY  & bvalid_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;
    assign r_hs  = S_AXI_RREADY  & rvalid_q;

`ifdef AXIL_MMAP_ADDR_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] WIN_SIZE = ADDR_WIDTH'(NUM_REGS) << SLOT_LOG2;
    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    assign aw_ok = (awaddr_q - BASE_ADDR) < WIN_SIZE;
    assign ar_ok = (S_AXI_ARADDR - BASE_ADDR) < WIN_SIZE;
`else
    assign aw_ok = 1'b1;
    assign ar_ok = 1'b1;
`endif

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q, S_AXI_ARADDR};

    axilite_mmap_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .we_i   (reg_we),
        .widx_i (awaddr_q[SLOT_LOG2 +: IDX_W]),
        .wdata_i(S_AXI_WDATA),
        .wstrb_i(S_AXI_WSTRB),
        .ridx_i (S_AXI_ARADDR[SLOT_LOG2 +: IDX_W]),
        .rdata_o(reg_rdata)
    );

    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        bresp_d  = bresp_q;
        reg_we   = 1'b0;
        unique case (wstate_q)
            W_ADDR: if (aw_hs) begin
                awaddr_d = S_AXI_AWADDR;
                wstate_d = W_DATA;
            end
            W_DATA: if (w_hs) begin
                reg_we   = aw_ok;
                bresp_d  = aw_ok ? RESP_OKAY : RESP_SLVERR;
                wstate_d = W_RESP;
            end
            W_RESP: if (b_hs) wstate_d = W_ADDR;
            default: wstate_d = W_ADDR;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_ADDR: if (ar_hs) begin
                rdata_d  = ar_ok ? reg_rdata : '0;
                rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
                rstate_d = R_DATA;
            end
            R_DATA: if (r_hs) rstate_d = R_ADDR;
            default: rstate_d = R_ADDR;
        endcase
    end

    // Handshake outputs are registered copies of the next state, so READY
    // stays low through reset and rises on the first edge after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wstate_q  <= W_ADDR;
            rstate_q  <= R_ADDR;
            awaddr_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            awaddr_q  <= awaddr_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            awready_q <= (wstate_d == W_ADDR);
            wready_q  <= (wstate_d == W_DATA);
            bvalid_q  <= (wstate_d == W_RESP);
            arready_q <= (rstate_d == R_ADDR);
            rvalid_q  <= (rstate_d == R_DATA);
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axilite_slave_mmap.sv
// Bench for axilite_slave_mmap: directed test-plan sequences with literal
// expectations, then random traffic, all cross-checked each cycle by a model.
module tb_axilite_slave_mmap;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0, S_AXI_WDATA = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0;
    logic        S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    axilite_slave_mmap dut (
        .clock(clock), .reset_n(reset_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
    );

    // ---------------- reference model ----------------
    logic [31:0] mem [4] = '{default: '0};
    logic [31:0] m_waddr = '0, m_rdata = '0;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    int          wph = 0, rph = 0;   // 0 address, 1 data, 2 response
    logic        awake = 1'b0;       // low from reset until the first edge after it

    function automatic logic in_win(input logic [31:0] a);
`ifdef AXIL_MMAP_ADDR_ERR_EN
        return (a >= 32'h0001_0000) && (a < 32'h0002_0000);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int slot(input logic [31:0] a);
        return int'((a / 32'h4000) % 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            m_waddr <= '0; m_rdata <= '0; m_bresp <= '0; m_rresp <= '0;
            wph <= 0; rph <= 0; awake <= 1'b0;
        end else begin
            awake <= 1'b1;
            if (awake && rph == 0 && S_AXI_ARVALID) begin
                m_rdata <= in_win(S_AXI_ARADDR) ? mem[slot(S_AXI_ARADDR)] : 32'h0;
                m_rresp <= in_win(S_AXI_ARADDR) ? 2'b00 : 2'b10;
                rph <= 1;
            end else if (rph == 1 && S_AXI_RREADY) begin
                rph <= 0;
            end
            if (awake && wph == 0 && S_AXI_AWVALID) begin
                m_waddr <= S_AXI_AWADDR;
                wph <= 1;
            end else if (wph == 1 && S_AXI_WVALID) begin
                if (in_win(m_waddr))
                    mem[slot(m_waddr)] <= merge(mem[slot(m_waddr)], S_AXI_WDATA, S_AXI_WSTRB);
                m_bresp <= in_win(m_waddr) ? 2'b00 : 2'b10;
                wph <= 2;
            end else if (wph == 2 && S_AXI_BREADY) begin
                wph <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("awready", {31'b0, S_AXI_AWREADY}, {31'b0, awake && wph == 0});
        chk("wready",  {31'b0, S_AXI_WREADY},  {31'b0, wph == 1});
        chk("bvalid",  {31'b0, S_AXI_BVALID},  {31'b0, wph == 2});
        chk("bresp",   {30'b0, S_AXI_BRESP},   {30'b0, m_bresp});
        chk("arready", {31'b0, S_AXI_ARREADY}, {31'b0, awake && rph == 0});
        chk("rvalid",  {31'b0, S_AXI_RVALID},  {31'b0, rph == 1});
        chk("rresp",   {30'b0, S_AXI_RRESP},   {30'b0, m_rresp});
        chk("rdata",   S_AXI_RDATA,            m_rdata);
    end

    // ---------------- directed master ----------------
    // sel: 0 AW, 1 W, 2 B, 3 AR, 4 R. Returns response data/code seen at the handshake.
    task automatic wait_hs(input int sel, output logic [31:0] d, output logic [1:0] r);
        bit seen = 0;
        d = '0; r = '0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            case (sel)
                0: seen = S_AXI_AWREADY;
                1: seen = S_AXI_WREADY;
                2: seen = S_AXI_BVALID;
                3: seen = S_AXI_ARREADY;
                default: seen = S_AXI_RVALID;
            endcase
            d = S_AXI_RDATA;
            r = (sel == 2) ? S_AXI_BRESP : S_AXI_RRESP;
            @(posedge clock); #1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: channel %0d got no handshake expected one within 50 cycles", sel);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic [31:0] dd;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        wait_hs(0, dd, resp);
        S_AXI_AWVALID = 0;
        wait_hs(1, dd, resp);
        S_AXI_WVALID = 0; S_AXI_BREADY = 1;
        wait_hs(2, dd, resp);
        S_AXI_BREADY = 0;
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a,
                             input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d;
        logic [1:0]  r;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        wait_hs(3, d, r);
        S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
        wait_hs(4, d, r);
        S_AXI_RREADY = 0;
        chk(name, d, exp_d);
        chk({name, "_rresp"}, {30'b0, r}, {30'b0, exp_r});
    endtask

    task automatic wr_expect(input string name, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_r);
        logic [1:0] r;
        axi_write(a, d, s, r);
        chk({name, "_bresp"}, {30'b0, r}, {30'b0, exp_r});
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_awready", {31'b0, S_AXI_AWREADY}, 32'h0);
        chk("rst_arready", {31'b0, S_AXI_ARREADY}, 32'h0);
        reset_n = 1;
        @(posedge clock); #1;

        rd_expect("init_r0", 32'h0001_0000, 32'h0, 2'b00);
        rd_expect("init_r1", 32'h0001_4000, 32'h0, 2'b00);
        rd_expect("init_r2", 32'h0001_8000, 32'h0, 2'b00);
        rd_expect("init_r3", 32'h0001_C000, 32'h0, 2'b00);

        wr_expect("w_r0", 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 2'b00);
        wr_expect("w_r1", 32'h0001_4000, 32'h1234_5678, 4'hF, 2'b00);
        wr_expect("w_r2", 32'h0001_8000, 32'hABCD_EF01, 4'hF, 2'b00);
        wr_expect("w_r3", 32'h0001_C000, 32'h8765_4321, 4'hF, 2'b00);
        rd_expect("rb_r0", 32'h0001_0000, 32'hDEAD_BEEF, 2'b00);
        rd_expect("rb_r1", 32'h0001_4000, 32'h1234_5678, 2'b00);
        rd_expect("rb_r2", 32'h0001_8000, 32'hABCD_EF01, 2'b00);
        rd_expect("rb_r3", 32'h0001_C000, 32'h8765_4321, 2'b00);

        wr_expect("s_r0", 32'h0001_0000, 32'h0000_00FF, 4'h1, 2'b00);
        wr_expect("s_r1", 32'h0001_4000, 32'hAA00_0000, 4'h8, 2'b00);
        wr_expect("s_r2", 32'h0001_8000, 32'h0000_FFFF, 4'h6, 2'b00);
        wr_expect("s_r3", 32'h0001_C000, 32'hFFFF_FFFF, 4'h0, 2'b00);
        rd_expect("strb_r0", 32'h0001_0000, 32'hDEAD_BEFF, 2'b00);
        rd_expect("strb_r1", 32'h0001_4123, 32'hAA34_5678, 2'b00);
        rd_expect("strb_r2", 32'h0001_8000, 32'hAB00_FF01, 2'b00);
        rd_expect("strb_r3", 32'h0001_C000, 32'h8765_4321, 2'b00);

        // reset during an in-flight read
        S_AXI_ARADDR = 32'h0001_0000; S_AXI_ARVALID = 1;
        @(posedge clock); #1;
        reset_n = 0; S_AXI_ARVALID = 0;
        #50;
        reset_n = 1;
        @(posedge clock); #1;
        rd_expect("prst_r0", 32'h0001_0000, 32'h0, 2'b00);
        rd_expect("prst_r1", 32'h0001_4000, 32'h0, 2'b00);
        rd_expect("prst_r2", 32'h0001_8000, 32'h0, 2'b00);
        rd_expect("prst_r3", 32'h0001_C000, 32'h0, 2'b00);

        wr_expect("b0", 32'h0001_0000, 32'h0000_0011, 4'h1, 2'b00);
        wr_expect("b1", 32'h0001_0004, 32'h0000_2200, 4'h2, 2'b00);
        wr_expect("b2", 32'h0001_0008, 32'h0033_0000, 4'h4, 2'b00);
        wr_expect("b3", 32'h0001_3FFC, 32'h4400_0000, 4'h8, 2'b00);
        rd_expect("bytes_r0", 32'h0001_0000, 32'h4433_2211, 2'b00);

        // AW/W held past their handshakes with BREADY high; WDATA changes after the
        // W handshake so a stray second write would be visible
        S_AXI_AWADDR = 32'h0001_4000; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        S_AXI_WDATA = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        repeat (2) @(posedge clock);
        #1;
        rd_expect("hold_r1", 32'h0001_4000, 32'h0BAD_F00D, 2'b00);

`ifdef AXIL_MMAP_ADDR_ERR_EN
        rd_expect("oob_rd", 32'h0002_0000, 32'h0, 2'b10);
        wr_expect("oob_wr", 32'h0002_0000, 32'h9999_9999, 4'hF, 2'b10);
        rd_expect("oob_r0", 32'h0001_0000, 32'h4433_2211, 2'b00);
        rd_expect("oob_low", 32'h0000_FFFC, 32'h0, 2'b10);
`else
        rd_expect("alias_rd", 32'h0002_0000, 32'h4433_2211, 2'b00);
        wr_expect("alias_wr", 32'h0002_0000, 32'h9999_9999, 4'hF, 2'b00);
        rd_expect("alias_r0", 32'h0001_0000, 32'h9999_9999, 2'b00);
        rd_expect("alias_r1", 32'hFFFF_4000, 32'h0BAD_F00D, 2'b00);
`endif

        // free-running random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            S_AXI_AWVALID = 1'($urandom_range(0, 1));
            S_AXI_WVALID  = 1'($urandom_range(0, 1));
            S_AXI_BREADY  = 1'($urandom_range(0, 1));
            S_AXI_ARVALID = 1'($urandom_range(0, 1));
            S_AXI_RREADY  = 1'($urandom_range(0, 1));
            S_AXI_AWPROT  = 3'($urandom_range(0, 7));
            S_AXI_ARPROT  = 3'($urandom_range(0, 7));
            S_AXI_WDATA   = $urandom;
            S_AXI_WSTRB   = 4'($urandom_range(0, 15));
            S_AXI_AWADDR  = ($urandom_range(0, 3) == 0) ? $urandom
                          : 32'h0001_0000 + $urandom_range(0, 32'hFFFF);
            S_AXI_ARADDR  = ($urandom_range(0, 3) == 0) ? $urandom
                          : 32'h0001_0000 + $urandom_range(0, 32'hFFFF);
            @(posedge clock); #1;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        repeat (5) @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
